// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and frame format constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK
  } rx_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam int   FRAME_STOP_BITS = 2;
  localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle line level.
module uart_rx_synchronizer
  import uart_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, even parity, 2 stop bits; single-entry output holder.
// Optional parity checking is enabled with `define UART_RX_PARITY_CHECK_EN.
// Handshake: a byte transfers on any posedge where DataValid && DataReady; DataOut/ParityError
// hold steady while DataValid=1 and DataReady=0, and a same-edge load keeps DataValid high.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 1
) (
  input  logic      Clock,
  input  logic      Reset,
  input  logic      SerialIn,
  output logic [7:0] DataOut,
  output logic      DataValid,
  input  logic      DataReady,
  output logic      ParityError,
  output logic      FramingError,
  output logic      Overrun,
  output rx_state_e DebugState
);

  localparam int         HALF     = (CLOCKS_PER_BIT - 1) / 2;
  localparam logic [3:0] RELOAD   = 4'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0] HALF_M1  = 4'((HALF == 0) ? 0 : HALF - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  logic      sync_in;
  rx_state_e state, state_n;
  logic [3:0] timer, timer_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic      load, fe_n, ov_n;
  logic      sample, holder_free;
`ifdef UART_RX_PARITY_CHECK_EN
  logic      par_bad, par_bad_n;
`endif

  uart_rx_synchronizer u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     (SerialIn),
    .q     (sync_in)
  );

  assign sample      = (timer == 4'd0);
  assign holder_free = !DataValid || DataReady;
  assign DebugState  = state;

  always_comb begin
    state_n   = state;
    timer_n   = (timer != 4'd0) ? timer - 4'd1 : timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    load      = 1'b0;
    fe_n      = 1'b0;
    ov_n      = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: begin
        bit_cnt_n = 3'd0;
        if (!sync_in) begin
          // Very short bit periods have no room for a separate start-bit confirmation
          if (HALF == 0) begin
            state_n = DATA;
            timer_n = RELOAD;
          end else begin
            state_n = START;
            timer_n = HALF_M1;
          end
        end
      end
      START: if (sample) begin
        timer_n = RELOAD;
        state_n = sync_in ? IDLE : DATA;
      end
      DATA: if (sample) begin
        timer_n   = RELOAD;
        shift_n   = {sync_in, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == LAST_BIT) state_n = PARITY;
      end
      PARITY: if (sample) begin
        timer_n = RELOAD;
`ifdef UART_RX_PARITY_CHECK_EN
        par_bad_n = ^{shift, sync_in};
`endif
        state_n = STOP1;
      end
      STOP1: if (sample) begin
        timer_n = RELOAD;
        if (!sync_in) begin
          fe_n    = 1'b1;
          state_n = BREAK;
        end else begin
          state_n = STOP2;
        end
      end
      STOP2: if (sample) begin
        timer_n = RELOAD;
        if (!sync_in) begin
          fe_n    = 1'b1;
          state_n = BREAK;
        end else begin
          state_n = IDLE;
          if (holder_free) load = 1'b1;
          else             ov_n = 1'b1;
        end
      end
      BREAK: if (sync_in) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      timer        <= 4'd0;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      DataOut      <= 8'h00;
      DataValid    <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      FramingError <= fe_n;
      Overrun      <= ov_n;
      if (load) begin
        DataOut   <= shift;
        DataValid <= 1'b1;
      end else if (DataValid && DataReady) begin
        DataValid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      par_bad     <= 1'b0;
      ParityError <= 1'b0;
    end else begin
      par_bad <= par_bad_n;
      if (load) ParityError <= par_bad;
    end
  end
`else
  assign ParityError = 1'b0;
`endif

endmodule
